// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic single-transfer RAM responder with programmable wait states.
// Define WB_RAM_ERR_EN to terminate out-of-window accesses with wb_err_out instead of aliasing.
module wb_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_adr_in,
  input  logic [31:0] wb_dat_in,
  input  logic [3:0]  wb_sel_in,
  output logic [31:0] wb_dat_out,
  output logic        wb_ack_out,
  output logic        wb_err_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t        state, state_next;
  logic [3:0]    wait_cnt, wait_cnt_next;
  logic          capture;
  logic          mem_we;
  logic          rd_load;

  logic [AW-1:0] idx_q;
  logic          we_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          range_err_q;

  logic [31:0]   offset;
  logic [AW-1:0] idx_in;
  logic          range_err_in;
  logic          unused_addr_bits;

  logic [AW-1:0] mem_idx;
  logic          cur_we;
  logic          cur_err;

  logic [31:0]   mem [DEPTH_WORDS];

  // The base is window-aligned, so the word index is a plain slice of the offset.
  assign offset           = wb_adr_in - BASE_ADDR;
  assign idx_in           = offset[AW+1:2];
  assign unused_addr_bits = ^{offset[31:AW+2], offset[1:0]};

`ifdef WB_RAM_ERR_EN
  assign range_err_in = (offset >> (AW + 2)) != 32'd0;
`else
  assign range_err_in = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      dat_q       <= 32'd0;
      sel_q       <= 4'd0;
      range_err_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (capture) begin
        idx_q       <= idx_in;
        we_q        <= wb_we_in;
        dat_q       <= wb_dat_in;
        sel_q       <= wb_sel_in;
        range_err_q <= range_err_in;
      end
    end
  end

  // Dropping wb_cyc_in after capture aborts silently; wb_stb_in is only looked at in IDLE.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    mem_we        = 1'b0;
    wb_ack_out    = 1'b0;
    wb_err_out    = 1'b0;
    case (state)
      IDLE: begin
        if (wb_cyc_in && wb_stb_in) begin
          capture       = 1'b1;
          wait_cnt_next = 4'(WAIT_STATES);
          state_next    = (WAIT_STATES == 0) ? RESPOND : WAIT;
        end
      end
      WAIT: begin
        if (!wb_cyc_in) begin
          state_next    = IDLE;
          wait_cnt_next = 4'd0;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state_next = RESPOND;
        end
      end
      RESPOND: begin
        state_next    = IDLE;
        wait_cnt_next = 4'd0;
        if (wb_cyc_in) begin
          wb_ack_out = !range_err_q;
          mem_we     = we_q && !range_err_q;
`ifdef WB_RAM_ERR_EN
          wb_err_out = range_err_q;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One RAM port: the live address in IDLE (zero-wait reads), the captured one afterwards.
  always_comb begin
    mem_idx = idx_q;
    cur_we  = we_q;
    cur_err = range_err_q;
    if (state == IDLE) begin
      mem_idx = idx_in;
      cur_we  = wb_we_in;
      cur_err = range_err_in;
    end
    rd_load = (state_next == RESPOND) && !cur_we && !cur_err;
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[mem_idx][8*i +: 8] <= dat_q[8*i +: 8];
      end
    end
  end

  // Read data is fetched on the edge entering RESPOND and then held until the next read.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wb_dat_out <= 32'd0;
    end else if (rd_load) begin
      wb_dat_out <= mem[mem_idx];
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: port 0 runs WAIT_STATES=1, port 1 runs WAIT_STATES=0.
// Expectations follow WB_RAM_ERR_EN the same way the design does.
module tb_wb_ram_slave;

  localparam int WS0 = 1;
  localparam int WS1 = 0;

`ifdef WB_RAM_ERR_EN
  localparam bit OOR_ERR = 1'b1;
`else
  localparam bit OOR_ERR = 1'b0;
`endif

  typedef struct {
    int          port;
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
    int          exp_cycle;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       cyc = '0;
  logic [1:0]       stb = '0;
  logic [1:0]       we = '0;
  logic [1:0][31:0] adr = '0;
  logic [1:0][31:0] wdat = '0;
  logic [1:0][3:0]  sel = '0;
  wire  [1:0]       ack;
  wire  [1:0]       err;
  wire  [1:0][31:0] rdat;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  bit   seen;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wb_ram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(WS0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk_in(clk), .reset_in(reset_n), .wb_cyc_in(cyc[0]), .wb_stb_in(stb[0]),
    .wb_we_in(we[0]), .wb_adr_in(adr[0]), .wb_dat_in(wdat[0]), .wb_sel_in(sel[0]),
    .wb_dat_out(rdat[0]), .wb_ack_out(ack[0]), .wb_err_out(err[0]));

  wb_ram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(WS1), .BASE_ADDR(32'h0)) u_dut1 (
    .clk_in(clk), .reset_in(reset_n), .wb_cyc_in(cyc[1]), .wb_stb_in(stb[1]),
    .wb_we_in(we[1]), .wb_adr_in(adr[1]), .wb_dat_in(wdat[1]), .wb_sel_in(sel[1]),
    .wb_dat_out(rdat[1]), .wb_ack_out(ack[1]), .wb_err_out(err[1]));

  function automatic exp_t mk(input int p, input bit is_err, input bit chk,
                              input logic [31:0] data, input int exp_cycle);
    exp_t e;
    e.port      = p;
    e.is_err    = is_err;
    e.chk_data  = chk;
    e.data      = data;
    e.exp_cycle = exp_cycle;
    return e;
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Termination kind encoding: 2 = ack only, 1 = err only.
  task automatic checkOutput(input int p);
    exp_t e;
    if (exp_q.size() == 0) begin
      compare($sformatf("unexpected_term_p%0d", p), {30'd0, ack[p], err[p]}, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    compare("term_port", 32'(p), 32'(e.port));
    compare("term_kind", {30'd0, ack[p], err[p]}, e.is_err ? 32'd1 : 32'd2);
    compare("term_cycle", 32'(cycle), 32'(e.exp_cycle));
    if (e.chk_data) compare("read_data", rdat[p], e.data);
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (ack[p] || err[p]) checkOutput(p);
    end
  end

  task automatic busStart(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    cyc[p]  = 1'b1;
    stb[p]  = 1'b1;
    we[p]   = w;
    adr[p]  = a;
    wdat[p] = d;
    sel[p]  = s;
  endtask

  task automatic busEnd(input int p);
    cyc[p] = 1'b0;
    stb[p] = 1'b0;
    we[p]  = 1'b0;
  endtask

  task automatic waitTerm(input int p, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack[p] || err[p]) begin
        got = 1'b1;
        break;
      end
    end
    compare($sformatf("term_seen_p%0d", p), {31'd0, got}, 32'd1);
  endtask

  task automatic applyStimulus(input int p, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input bit exp_err, input bit chk,
                               input logic [31:0] exp_data, input bit drop_stb);
    bit got;
    @(posedge clk); #1;
    exp_q.push_back(mk(p, exp_err, chk, exp_data, cycle + 1 + ((p == 0) ? WS0 : WS1)));
    busStart(p, w, a, d, s);
    if (drop_stb) begin
      @(posedge clk); #1;
      stb[p] = 1'b0;
    end
    waitTerm(p, got);
    @(posedge clk); #1;
    busEnd(p);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      compare($sformatf("reset_ack_p%0d", p), {31'd0, ack[p]}, 32'd0);
      compare($sformatf("reset_err_p%0d", p), {31'd0, err[p]}, 32'd0);
      compare($sformatf("reset_dout_p%0d", p), rdat[p], 32'd0);
    end
    reset_n = 1'b1;

    // Full-word write then readback, two-cycle latency each.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Byte-lane merge, ignored low address bits, sel not affecting reads, empty-sel write.
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11BB33DD, 1'b0);
    applyStimulus(0, 1'b0, 32'h22, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11BB33DD, 1'b0);
    applyStimulus(0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 32'h11BB33DD, 1'b0);

    // Cycle drop during WAIT aborts the write.
    applyStimulus(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    busStart(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    busEnd(0);
    repeat (3) @(posedge clk);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);

    // Strobe drop with cycle held still completes.
    applyStimulus(0, 1'b1, 32'h30, 32'h0F0F0F0F, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0F0F0F0F, 1'b0);

    // Out-of-window access: error termination or alias onto word 0.
    applyStimulus(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, OOR_ERR, OOR_ERR, 32'h0F0F0F0F, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1,
                  OOR_ERR ? 32'hCAFEF00D : 32'h5A5A5A5A, 1'b0);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'hF, OOR_ERR, 1'b1,
                  OOR_ERR ? 32'hCAFEF00D : 32'h5A5A5A5A, 1'b0);

    // Asynchronous reset while the write sits in WAIT.
    @(posedge clk); #1;
    busStart(0, 1'b1, 32'h10, 32'h12345678, 4'hF);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    compare("async_reset_ack", {31'd0, ack[0]}, 32'd0);
    compare("async_reset_err", {31'd0, err[0]}, 32'd0);
    compare("async_reset_dout", rdat[0], 32'd0);
    busEnd(0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Zero-wait port: single-cycle latency and back-to-back reads with strobe held.
    applyStimulus(1, 1'b1, 32'h0, 32'h01010101, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 32'h4, 32'h02020202, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp_q.push_back(mk(1, 1'b0, 1'b1, 32'h01010101, cycle + 1));
    exp_q.push_back(mk(1, 1'b0, 1'b1, 32'h02020202, cycle + 3));
    busStart(1, 1'b0, 32'h0, 32'h0, 4'hF);
    waitTerm(1, seen);
    @(posedge clk); #1;
    adr[1] = 32'h4;
    waitTerm(1, seen);
    @(posedge clk); #1;
    busEnd(1);

    repeat (5) @(posedge clk);
    compare("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
